// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard control unit.
// The datapath side (master) reports hazard sources; the control unit (slave) returns enables/flushes.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [15:0]      id_instr;
    logic             ex_memread;
    logic [3:0]       ex_rd;
    logic             branch_taken;
    logic             icache_miss;
    logic             dcache_miss;

    logic             pc_wen;
    logic             pc_sel_branch;
    logic             if_id_wen;
    logic             if_id_flush;
    logic             id_ex_wen;
    logic             id_ex_flush;
    logic             ex_mem_wen;
    logic             mem_wb_wen;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_instr, ex_memread, ex_rd, branch_taken, icache_miss, dcache_miss,
        input  pc_wen, pc_sel_branch, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush,
               ex_mem_wen, mem_wb_wen, halted, stall_cnt
    );

    modport slave (
        input  id_valid, id_instr, ex_memread, ex_rd, branch_taken, icache_miss, dcache_miss,
        output pc_wen, pc_sel_branch, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush,
               ex_mem_wen, mem_wb_wen, halted, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: stall/flush generation for load-use, cache misses, taken branches and HLT drain.
// Enables and flushes are Mealy outputs; halted follows the state register, stall_cnt is registered.
module pipe_hazard_ctrl #(
    parameter int unsigned DRAIN_CYC = 3,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int unsigned DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DCNT_W-1:0] drain_cnt;
    logic [CNT_W-1:0]  stall_q;

    logic [3:0] opcode;
    logic [3:0] f_d;
    logic [3:0] f_rs;
    logic [3:0] f_rt;
    logic       reads_rs;
    logic       reads_rt;
    logic       reads_d;
    logic       load_use;
    logic       is_hlt;
    logic       drain_done;

    logic pc_wen;
    logic pc_sel_branch;
    logic if_id_wen;
    logic if_id_flush;
    logic id_ex_wen;
    logic id_ex_flush;
    logic ex_mem_wen;
    logic mem_wb_wen;
    logic halted;

    assign opcode = bus.id_instr[15:12];
    assign f_d    = bus.id_instr[11:8];
    assign f_rs   = bus.id_instr[7:4];
    assign f_rt   = bus.id_instr[3:0];

    // Which register fields the instruction in ID actually reads.
    always_comb begin
        reads_rs = (opcode <= 4'h9) || (opcode == 4'hD);
        reads_rt = (opcode <= 4'h3) || (opcode == 4'h7);
        reads_d  = (opcode == 4'h9) || (opcode == 4'hA) || (opcode == 4'hB);
    end

    // R0 is hardwired, so a load to R0 never creates a dependency.
    always_comb begin
        load_use = bus.id_valid && bus.ex_memread && (bus.ex_rd != 4'd0) &&
                   ((reads_rs && (f_rs == bus.ex_rd)) ||
                    (reads_rt && (f_rt == bus.ex_rd)) ||
                    (reads_d  && (f_d  == bus.ex_rd)));
        is_hlt   = bus.id_valid && (opcode == 4'hF);
    end

    assign drain_done = (drain_cnt == DRAIN_LAST) && !bus.dcache_miss;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN: begin
                if (is_hlt && !bus.dcache_miss && !load_use) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RUN;
        endcase
    end

    // Drain progress only advances on cycles where MEM is not frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (state != ST_DRAIN) begin
            drain_cnt <= '0;
        end else if (!bus.dcache_miss && (drain_cnt != DRAIN_LAST)) begin
            drain_cnt <= drain_cnt + DCNT_W'(1);
        end
    end

    // Output logic.
    always_comb begin
        pc_wen        = 1'b1;
        pc_sel_branch = 1'b0;
        if_id_wen     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_wen     = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_wen    = 1'b1;
        mem_wb_wen    = 1'b1;
        halted        = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (bus.dcache_miss) begin
                    pc_wen     = 1'b0;
                    if_id_wen  = 1'b0;
                    id_ex_wen  = 1'b0;
                    ex_mem_wen = 1'b0;
                    mem_wb_wen = 1'b0;
                end else if (load_use) begin
                    pc_wen      = 1'b0;
                    if_id_wen   = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (is_hlt) begin
                    pc_wen      = 1'b0;
                    if_id_flush = 1'b1;
                end else if (bus.branch_taken) begin
                    pc_sel_branch = 1'b1;
                    if_id_flush   = 1'b1;
                end else if (bus.icache_miss) begin
                    pc_wen      = 1'b0;
                    if_id_flush = 1'b1;
                end
            end
            ST_DRAIN: begin
                pc_wen      = 1'b0;
                if_id_flush = 1'b1;
                if (bus.dcache_miss) begin
                    id_ex_wen  = 1'b0;
                    ex_mem_wen = 1'b0;
                    mem_wb_wen = 1'b0;
                end else begin
                    id_ex_flush = 1'b1;
                end
            end
            ST_HALTED: begin
                pc_wen     = 1'b0;
                if_id_wen  = 1'b0;
                id_ex_wen  = 1'b0;
                ex_mem_wen = 1'b0;
                mem_wb_wen = 1'b0;
                halted     = 1'b1;
            end
            default: ;
        endcase
    end

    // Saturating count of stalled fetch cycles before halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (!pc_wen && (state != ST_HALTED) && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign bus.pc_wen        = pc_wen;
    assign bus.pc_sel_branch = pc_sel_branch;
    assign bus.if_id_wen     = if_id_wen;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.id_ex_wen     = id_ex_wen;
    assign bus.id_ex_flush   = id_ex_flush;
    assign bus.ex_mem_wen    = ex_mem_wen;
    assign bus.mem_wb_wen    = mem_wb_wen;
    assign bus.halted        = halted;
    assign bus.stall_cnt     = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: each vector queues its expected control word,
// a negedge monitor pops and compares against the DUT outputs.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();

    pipe_hazard_ctrl #(.DRAIN_CYC(3), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {pc_wen, pc_sel_branch, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, ex_mem_wen, mem_wb_wen, halted}
    localparam logic [8:0] O_NORM  = 9'b1_0_1_0_1_0_1_1_0;
    localparam logic [8:0] O_LU    = 9'b0_0_0_0_1_1_1_1_0;
    localparam logic [8:0] O_FRZ   = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] O_HLTR  = 9'b0_0_1_1_1_0_1_1_0;
    localparam logic [8:0] O_BR    = 9'b1_1_1_1_1_0_1_1_0;
    localparam logic [8:0] O_IC    = 9'b0_0_1_1_1_0_1_1_0;
    localparam logic [8:0] O_DRN   = 9'b0_0_1_1_1_1_1_1_0;
    localparam logic [8:0] O_DRNDC = 9'b0_0_1_1_0_0_0_0_0;
    localparam logic [8:0] O_HALT  = 9'b0_0_0_0_0_0_0_0_1;

    typedef struct {
        logic [8:0]  o;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] tally  = 16'd0;

    task automatic drive(input logic v, input logic [15:0] ins, input logic mr,
                         input logic [3:0] rd, input logic br, input logic ic, input logic dc);
        bus.id_valid     = v;
        bus.id_instr     = ins;
        bus.ex_memread   = mr;
        bus.ex_rd        = rd;
        bus.branch_taken = br;
        bus.icache_miss  = ic;
        bus.dcache_miss  = dc;
    endtask

    // One cycle of stimulus plus its expected response; stall tally follows the expected pc_wen.
    task automatic apply(input logic v, input logic [15:0] ins, input logic mr, input logic [3:0] rd,
                         input logic br, input logic ic, input logic dc,
                         input logic [8:0] o, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        drive(v, ins, mr, rd, br, ic, dc);
        e.o    = o;
        e.cnt  = tally;
        e.name = nm;
        sb.push_back(e);
        if (!o[8] && !o[0]) tally = tally + 16'd1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        drive(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        tally = 16'd0;
    endtask

    // Monitor: compare whenever a queued expectation exists for this cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [8:0]  act;
            e   = sb.pop_front();
            act = {bus.pc_wen, bus.pc_sel_branch, bus.if_id_wen, bus.if_id_flush, bus.id_ex_wen,
                   bus.id_ex_flush, bus.ex_mem_wen, bus.mem_wb_wen, bus.halted};
            n_vec = n_vec + 1;
            if (act !== e.o) begin
                n_miss = n_miss + 1;
                $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.o);
            end
            n_vec = n_vec + 1;
            if (bus.stall_cnt !== e.cnt) begin
                n_miss = n_miss + 1;
                $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, bus.stall_cnt, e.cnt);
            end
        end
    end

    initial begin
        drive(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        do_reset();

        // Reset state and load-use through rs
        apply(0, 16'h0000, 0, 4'd0, 0, 0, 0, O_NORM, "reset_idle");
        apply(1, 16'h0531, 1, 4'd3, 0, 0, 0, O_LU,   "lu_rs");
        apply(1, 16'h0531, 0, 4'd0, 0, 0, 0, O_NORM, "lu_after");

        // Register 0, rt, [11:8] sources and opcodes that do not read a field
        apply(1, 16'h0500, 1, 4'd0, 0, 0, 0, O_NORM, "lw_r0");
        apply(1, 16'hA3FF, 1, 4'd3, 0, 0, 0, O_LU,   "lu_llb_d");
        apply(1, 16'h0123, 1, 4'd3, 0, 0, 0, O_LU,   "lu_rt");
        apply(1, 16'h8123, 1, 4'd3, 0, 0, 0, O_NORM, "op8_no_rt");
        apply(1, 16'h4356, 1, 4'd3, 0, 0, 0, O_NORM, "op4_no_d");
        apply(0, 16'h0531, 1, 4'd3, 0, 0, 0, O_NORM, "lu_invalid");
        apply(1, 16'hD030, 1, 4'd3, 0, 0, 0, O_LU,   "lu_opD_rs");

        // dcache freeze over a load-use, then one bubble
        do_reset();
        for (int i = 0; i < 4; i++)
            apply(1, 16'h0531, 1, 4'd3, 0, 0, 1, O_FRZ, "dc_freeze");
        apply(1, 16'h0531, 1, 4'd3, 0, 0, 0, O_LU,   "dc_then_lu");
        apply(1, 16'h0531, 0, 4'd0, 0, 0, 0, O_NORM, "dc_lu_cnt5");

        // Branch and icache priorities
        apply(0, 16'h0000, 0, 4'd0, 1, 1, 0, O_BR,   "br_over_ic");
        apply(0, 16'h0000, 0, 4'd0, 0, 1, 0, O_IC,   "icache");
        apply(0, 16'h0000, 0, 4'd0, 1, 0, 1, O_FRZ,  "dc_over_br");
        apply(1, 16'h0531, 1, 4'd3, 1, 0, 0, O_LU,   "lu_over_br");

        // HLT drain with no misses
        do_reset();
        apply(1, 16'hF000, 0, 4'd0, 0, 0, 0, O_HLTR, "hlt_run");
        apply(0, 16'h0000, 0, 4'd0, 0, 0, 0, O_DRN,  "drain1");
        apply(0, 16'h0000, 0, 4'd0, 0, 0, 0, O_DRN,  "drain2");
        apply(0, 16'h0000, 0, 4'd0, 0, 0, 0, O_DRN,  "drain3");
        apply(0, 16'h0000, 0, 4'd0, 0, 0, 0, O_HALT, "halted");
        apply(1, 16'h0531, 1, 4'd3, 1, 1, 1, O_HALT, "halted_sticky");

        // HLT blocked by dcache, then one frozen drain cycle extends the drain
        do_reset();
        apply(1, 16'hF000, 0, 4'd0, 0, 0, 1, O_FRZ,   "hlt_dc_block");
        apply(1, 16'hF000, 0, 4'd0, 0, 0, 0, O_HLTR,  "hlt_run2");
        apply(0, 16'h0000, 0, 4'd0, 0, 0, 0, O_DRN,   "drain_a");
        apply(0, 16'h0000, 0, 4'd0, 0, 0, 1, O_DRNDC, "drain_dc");
        apply(0, 16'h0000, 0, 4'd0, 1, 1, 0, O_DRN,   "drain_ign_br");
        apply(0, 16'h0000, 0, 4'd0, 0, 0, 0, O_DRN,   "drain_last");
        apply(0, 16'h0000, 0, 4'd0, 0, 0, 0, O_HALT,  "halted2");

        // Asynchronous reset while halted
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_vec = n_vec + 1;
        if (bus.halted !== 1'b0 || bus.stall_cnt !== 16'd0) begin
            n_miss = n_miss + 1;
            $display("FAIL async_rst: got halted=%b cnt=%0d expected halted=0 cnt=0",
                     bus.halted, bus.stall_cnt);
        end
        drive(0, 16'h0000, 0, 4'd0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        tally = 16'd0;
        apply(0, 16'h0000, 0, 4'd0, 0, 0, 0, O_NORM, "post_rst");
        apply(1, 16'h0531, 1, 4'd3, 0, 0, 0, O_LU,   "post_rst_lu");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_vec  = n_vec + 1;
            n_miss = n_miss + 1;
            $display("FAIL drain_queue: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline control unit for the 5-stage 16-bit CPU. It generates write-enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves load-use hazards, D-/I-cache miss stalls, taken-branch squashes and HLT drain. It sits beside the pipeline registers and drives their stall/flush inputs.

Parameters:
DRAIN_CYC, 3, cycles after HLT leaves ID before halted asserts (EX, MEM, WB drain)
CNT_W, 16, width of the stall performance counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
id_valid  input  1  IF/ID holds a real (non-flushed) instruction
id_instr  input  16  instruction in ID; opcode=[15:12], rd=[11:8], rs=[7:4], rt=[3:0]
ex_memread  input  1  instruction in EX is LW
ex_rd  input  4  destination register of instruction in EX
branch_taken  input  1  ID resolved a taken B/BR this cycle
icache_miss  input  1  fetch not ready this cycle
dcache_miss  input  1  MEM access not ready this cycle
pc_wen  output  1  PC update enable
pc_sel_branch  output  1  PC loads branch target
if_id_wen  output  1  IF/ID write enable
if_id_flush  output  1  IF/ID loads NOP
id_ex_wen  output  1  ID/EX write enable
id_ex_flush  output  1  ID/EX loads bubble
ex_mem_wen  output  1  EX/MEM write enable
mem_wb_wen  output  1  MEM/WB write enable
halted  output  1  CPU halted, sticky until rst
stall_cnt  output  CNT_W  count of cycles with pc_wen=0 while not halted

Behaviour:
- Sources read in ID:
  - rs: opcodes 0x0–0x9 and 0xD.
  - rt: opcodes 0x0–0x3 and 0x7.
  - [11:8]: opcodes 0x9, 0xA and 0xB.
  - Register 0 never causes a hazard.
- load_use = id_valid & ex_memread & (ex_rd != 0) & ex_rd matches any read source.
- is_hlt = id_valid & (opcode == 0xF).
- FSM states:
  - RUN → DRAIN when is_hlt and no dcache_miss or load_use.
  - DRAIN → HALTED when drain counter reaches DRAIN_CYC-1. The counter increments only on cycles with dcache_miss=0.
  - HALTED holds until rst.
- Outputs are Mealy on state and inputs. Defaults: all wen=1, flush=0, pc_sel_branch=0.
- RUN priority, highest first:
  1. dcache_miss: every wen=0, no flush. Whole pipe frozen.
  2. load_use: pc_wen=0, if_id_wen=0, id_ex_flush=1. Exactly one bubble per hazard.
  3. is_hlt: pc_wen=0, if_id_flush=1.
  4. branch_taken: pc_sel_branch=1, if_id_flush=1, pc_wen=1. A simultaneous icache_miss is ignored.
  5. icache_miss: pc_wen=0, if_id_flush=1.
- DRAIN:
  - pc_wen=0 and if_id_flush=1 every cycle.
  - id_ex_flush=1 on every non-frozen cycle.
  - dcache_miss freezes ex_mem_wen and mem_wb_wen as in RUN.
  - branch_taken and icache_miss are ignored.
- HALTED: all wen=0, all flush=0, halted=1.
- stall_cnt increments (saturating at all-ones) on each cycle with pc_wen=0 and state != HALTED.
- Reset: state=RUN, drain counter=0, stall_cnt=0, halted=0. Reset mid-drain or while HALTED returns to RUN immediately, asynchronously.

Test Plan:
- LW R3 in EX, ID=ADD R5,R3,R1 (0x0531) → exactly one cycle with pc_wen=0, if_id_wen=0, id_ex_flush=1; next cycle all wen=1; stall_cnt=1.
- LW R0 in EX, ID=ADD R5,R0,R0 → no stall; ID=LLB R3 (0xA3xx) with ex_rd=3 and memread → stall.
- dcache_miss held 4 cycles during a load_use → all wen=0 for 4 cycles, then a single load-use bubble; stall_cnt=5.
- branch_taken with icache_miss=1 → pc_sel_branch=1, pc_wen=1, if_id_flush=1 the same cycle.
- HLT in ID (0xF000), no misses → DRAIN for 3 cycles, then halted=1 and all wen=0 permanently. One dcache_miss cycle during DRAIN extends halted by one cycle.
- Assert rst while HALTED, then release → halted=0, stall_cnt=0, all wen=1.
